key_search_ctrl: RTL and testbench
==================================

KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

Interface
REQ-001 SHALL have parameter MSG_DEP, default 32, number of decrypted message bytes checked.
REQ-002 SHALL have parameter KEY_BITS, default 22, width of the searched key space.
REQ-003 SHALL have port CLOCK_50 input 1 as the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset input 1 as a synchronous, active-high reset.
REQ-005 SHALL have port start input 1, a one-cycle pulse from the decryptor's done, meaning decrypted_in is valid.
REQ-006 SHALL have port decrypted_in input MSG_DEP x 8 (unpacked byte array), the decrypted message for the current key.
REQ-007 SHALL have port secret_key output 24, {zero pad, key counter}, feeding the shuffle stage.
REQ-008 SHALL have port restart output 1, a one-cycle pulse requesting the sequencer to rerun S init, shuffle and decrypt with the new secret_key.
REQ-009 SHALL have port busy output 1, high in SNAP, CHECK and NEXT_KEY.
REQ-010 SHALL have port key_found output 1, level, high in FOUND.
REQ-011 SHALL have port key_exhausted output 1, level, high in EXHAUSTED.

Function
REQ-012 SHALL implement states IDLE, SNAP, CHECK, NEXT_KEY, FOUND, EXHAUSTED.
REQ-013 SHALL, in IDLE with start=1, go to SNAP; start SHALL be ignored in any other state.
REQ-014 SHALL, in SNAP, register all of decrypted_in into an internal message buffer, clear the byte index to 0, and go to CHECK.
REQ-015 SHALL, in CHECK, examine one buffered byte per cycle at the byte index.
- Valid bytes: 0x61..0x7A.
- Invalid byte: go to NEXT_KEY at once (early abort).
- Valid byte at index MSG_DEP-1: go to FOUND.
- Otherwise: increment the index.
REQ-016 SHALL, in NEXT_KEY with key counter = 2^KEY_BITS-1, go to EXHAUSTED with no restart pulse.
REQ-017 SHALL otherwise, in NEXT_KEY, increment the key counter, pulse restart for exactly one cycle in the same cycle secret_key updates, and return to IDLE.
REQ-018 SHALL keep the key counter KEY_BITS wide, with no wrap-around past the maximum and secret_key[23:KEY_BITS]=0.
REQ-019 SHALL treat FOUND and EXHAUSTED as terminal until reset; secret_key holds the found or last key.
REQ-020 SHALL meet these cycle latencies, counted from start sampled at cycle 0:
- SNAP at cycle 1.
- Check of byte k at cycle 2+k.
- All-valid message: FOUND visible at cycle MSG_DEP+2.
- Invalid byte k: restart at cycle 2+k+1.

Reset
REQ-021 SHALL, on reset, set state=IDLE, key counter=0, index=0, buffer=0, restart=0, busy=0, key_found=0, key_exhausted=0.
REQ-022 SHALL give reset priority over start and over any state, including mid-CHECK, and never emit restart in a reset cycle.

Configuration
REQ-023 SHALL, with macro KEY_SEARCH_ALLOW_SPACE_EN defined, also accept 0x20 as a valid byte.
REQ-024 SHALL, without KEY_SEARCH_ALLOW_SPACE_EN, reject 0x20 as invalid.

Structure
REQ-025 SHALL take the following from shared package rc4_breaker_pkg:
- State enum type.
- MSG_DEP and KEY_BITS defaults.
- Character bounds CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SPACE=8'h20.
REQ-026 SHALL place byte validity in one combinational sub-module, byte_classifier (8-bit in, valid out), which holds the macro-dependent space rule.

Verification
REQ-027 SHALL cover: all 32 bytes 0x61, start at cycle 0 -> key_found=1 at cycle 34, secret_key=0, no restart.
REQ-028 SHALL cover: byte0=0x41, start -> restart pulse at cycle 3, secret_key=24'h000001, back in IDLE, busy=0.
REQ-029 SHALL cover: bytes0..30=0x7A, byte31=0x7B -> restart at cycle 34, key+1.
REQ-030 SHALL cover: key preset by 2^22-1 invalid runs to 0x3FFFFF, invalid message -> key_exhausted=1, no restart, secret_key=24'h3FFFFF.
REQ-031 SHALL cover: byte5=0x20, rest 0x61 -> key_found with KEY_SEARCH_ALLOW_SPACE_EN, restart at cycle 8 without it.
REQ-032 SHALL cover: reset at cycle 10 during CHECK -> next cycle IDLE, all outputs 0, secret_key=0; a start pulse while busy is ignored.

Source files
------------

// File: rtl/rc4_breaker_pkg.sv
// Shared types and constants for the RC4 key-breaker datapath.
// Holds the key-search FSM state type and the printable-byte bounds.
package rc4_breaker_pkg;

    localparam int unsigned MSG_DEP_DEF  = 32;
    localparam int unsigned KEY_BITS_DEF = 22;

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        StIdle,
        StSnap,
        StCheck,
        StNextKey,
        StFound,
        StExhausted
    } search_state_e;

endpackage

// File: rtl/key_search_ctrl_if.sv
// Handshake bundle between the decrypt sequencer (master) and key_search_ctrl (slave).
interface key_search_ctrl_if #(
    parameter int unsigned MSG_DEP = rc4_breaker_pkg::MSG_DEP_DEF
);
    logic        start;
    logic [7:0]  decrypted_in [MSG_DEP];
    logic [23:0] secret_key;
    logic        restart;
    logic        busy;
    logic        key_found;
    logic        key_exhausted;

    modport master (
        output start, decrypted_in,
        input  secret_key, restart, busy, key_found, key_exhausted
    );

    modport slave (
        input  start, decrypted_in,
        output secret_key, restart, busy, key_found, key_exhausted
    );
endinterface

// File: rtl/byte_classifier.sv
// Flags a decrypted byte as plausible plaintext (lowercase a..z).
// Define KEY_SEARCH_ALLOW_SPACE_EN to also accept the ASCII space.
module byte_classifier
    import rc4_breaker_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       valid_o
);
    logic is_lower;

    assign is_lower = (byte_i >= CHAR_LO) && (byte_i <= CHAR_HI);

`ifdef KEY_SEARCH_ALLOW_SPACE_EN
    assign valid_o = is_lower || (byte_i == CHAR_SPACE);
`else
    assign valid_o = is_lower;
`endif
endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key search controller: checks each decrypted message byte-by-byte and
// steps the key on failure. Byte acceptance depends on KEY_SEARCH_ALLOW_SPACE_EN.
module key_search_ctrl
    import rc4_breaker_pkg::*;
#(
    parameter int unsigned MSG_DEP  = MSG_DEP_DEF,
    parameter int unsigned KEY_BITS = KEY_BITS_DEF
) (
    input logic              CLOCK_50,
    input logic              reset,
    key_search_ctrl_if.slave bus
);
    localparam int unsigned IdxW = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1;
    localparam logic [IdxW-1:0]     LastIdx = IdxW'(MSG_DEP - 1);
    localparam logic [KEY_BITS-1:0] KeyMax  = '1;

    search_state_e       state_q, state_d;
    logic [7:0]          buf_q [MSG_DEP];
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic                restart_q, restart_d;
    logic                snap;
    logic                byte_ok;

    byte_classifier u_classifier (
        .byte_i  (buf_q[idx_q]),
        .valid_o (byte_ok)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        key_d     = key_q;
        restart_d = 1'b0;
        snap      = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StSnap;
            end
            StSnap: begin
                snap    = 1'b1;
                idx_d   = '0;
                state_d = StCheck;
            end
            StCheck: begin
                if (!byte_ok) begin
                    state_d = StNextKey;
                    // Key step is committed on entry to NEXT_KEY so restart and the new
                    // secret_key appear together; restart_q then tells NEXT_KEY the outcome.
                    if (key_q != KeyMax) begin
                        key_d     = key_q + 1'b1;
                        restart_d = 1'b1;
                    end
                end else if (idx_q == LastIdx) begin
                    state_d = StFound;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StNextKey: begin
                state_d = restart_q ? StIdle : StExhausted;
            end
            StFound, StExhausted: begin
                state_d = state_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            key_q     <= '0;
            restart_q <= 1'b0;
            buf_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            restart_q <= restart_d;
            if (snap) buf_q <= bus.decrypted_in;
        end
    end

    assign bus.secret_key    = 24'(key_q);
    assign bus.restart       = restart_q & ~reset;
    assign bus.busy          = (state_q == StSnap) || (state_q == StCheck) ||
                               (state_q == StNextKey);
    assign bus.key_found     = (state_q == StFound);
    assign bus.key_exhausted = (state_q == StExhausted);
endmodule

// File: tb/tb_key_search_ctrl.sv
// Self-checking bench for key_search_ctrl: per-cycle timeline model derived from the
// documented latencies, directed corner cases plus randomized messages.
module tb_key_search_ctrl;
    import rc4_breaker_pkg::*;

    localparam int unsigned MD   = 32;
    localparam int unsigned KB   = 5;
    localparam int          KMAX = (1 << KB) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_search_ctrl_if #(.MSG_DEP(MD)) bus ();

    key_search_ctrl #(
        .MSG_DEP  (MD),
        .KEY_BITS (KB)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  msg [MD];
    int          model_key;
    logic        exp_busy, exp_restart, exp_found, exp_exh;
    logic [23:0] exp_key;
    bit          chk_en = 1'b0;

    function automatic bit is_valid(input logic [7:0] b);
`ifdef KEY_SEARCH_ALLOW_SPACE_EN
        return (b >= 8'h61 && b <= 8'h7A) || (b == 8'h20);
`else
        return (b >= 8'h61 && b <= 8'h7A);
`endif
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",          24'(bus.busy),          24'(exp_busy));
            check("restart",       24'(bus.restart),       24'(exp_restart));
            check("key_found",     24'(bus.key_found),     24'(exp_found));
            check("key_exhausted", 24'(bus.key_exhausted), 24'(exp_exh));
            check("secret_key",    bus.secret_key,         exp_key);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit b, input bit r, input bit f, input bit e, input int key);
        exp_busy    = b;
        exp_restart = r;
        exp_found   = f;
        exp_exh     = e;
        exp_key     = 24'(key);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        model_key = 0;
        set_exp(0, 0, 0, 0, 0);
    endtask

    // Start pulse at cycle 0; expected outputs for cycle c follow from the first invalid byte k.
    task automatic run(input int reset_at, input int poke_at, output int ev_cycle,
                       output bit term);
        int k, last, old;
        bit all_ok, exh;
        old = model_key;
        k   = MD;
        for (int i = MD - 1; i >= 0; i--) if (!is_valid(msg[i])) k = i;
        all_ok   = (k == MD);
        exh      = !all_ok && (old == KMAX);
        last     = all_ok ? MD + 2 : k + 4;
        ev_cycle = all_ok ? MD + 2 : (exh ? k + 4 : k + 3);
        term     = all_ok || exh;
        bus.decrypted_in = msg;
        bus.start = 1'b1;
        step();
        for (int c = 1; c <= last; c++) begin
            bus.start = (c == poke_at);
            if (all_ok)   set_exp(c <= MD + 1, 0, c == MD + 2, 0, old);
            else if (exh) set_exp(c <= k + 3, 0, 0, c == k + 4, old);
            else          set_exp(c <= k + 3, c == k + 3, 0, 0, (c >= k + 3) ? old + 1 : old);
            if (c == reset_at) begin
                reset = 1'b1;
                step();
                reset     = 1'b0;
                bus.start = 1'b0;
                model_key = 0;
                term      = 1'b0;
                set_exp(0, 0, 0, 0, 0);
                return;
            end
            step();
        end
        bus.start = 1'b0;
        if (!all_ok && !exh) model_key = old + 1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < MD; i++) msg[i] = v;
    endtask

    initial begin
        int ev;
        bit term;
        reset     = 1'b1;
        bus.start = 1'b0;
        fill(8'h00);
        bus.decrypted_in = msg;
        model_key = 0;
        step();
        step();
        reset = 1'b0;
        set_exp(0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step();
        check("reset_busy", 24'(bus.busy), 24'h0);
        check("reset_key", bus.secret_key, 24'h0);

        // All 'a': found at cycle 34, key stays 0.
        fill(8'h61);
        run(0, 0, ev, term);
        check("all_a_cycle", 24'(ev), 24'd34);
        check("all_a_found", 24'(bus.key_found), 24'h1);
        check("all_a_key", bus.secret_key, 24'h0);
        do_reset();
        step();

        // Byte 0 invalid: restart at cycle 3, key 1, back idle.
        fill(8'h61);
        msg[0] = 8'h41;
        run(0, 0, ev, term);
        check("b0_cycle", 24'(ev), 24'd3);
        check("b0_key", bus.secret_key, 24'h000001);
        check("b0_busy", 24'(bus.busy), 24'h0);

        // Last byte just past 'z': restart at cycle 34.
        fill(8'h7A);
        msg[MD-1] = 8'h7B;
        run(0, 0, ev, term);
        check("b31_cycle", 24'(ev), 24'd34);
        check("b31_key", bus.secret_key, 24'h000002);

        // Space at byte 5.
        fill(8'h61);
        msg[5] = 8'h20;
        run(0, 0, ev, term);
`ifdef KEY_SEARCH_ALLOW_SPACE_EN
        check("space_cycle", 24'(ev), 24'd34);
        check("space_found", 24'(bus.key_found), 24'h1);
`else
        check("space_cycle", 24'(ev), 24'd8);
        check("space_key", bus.secret_key, 24'h000003);
`endif
        if (term) do_reset();

        // Reset mid-CHECK at cycle 10, with an ignored start pulse at cycle 5.
        fill(8'h61);
        run(10, 5, ev, term);
        check("midrst_busy", 24'(bus.busy), 24'h0);
        check("midrst_key", bus.secret_key, 24'h0);
        check("midrst_found", 24'(bus.key_found), 24'h0);
        step();

        // Randomized messages.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < MD; i++) begin
                if ((n % 10 == 9) || ($urandom_range(0, 7) != 0))
                    msg[i] = 8'($urandom_range(8'h61, 8'h7A));
                else
                    case ($urandom_range(0, 4))
                        0: msg[i] = 8'h20;
                        1: msg[i] = 8'h60;
                        2: msg[i] = 8'h7B;
                        3: msg[i] = 8'h41;
                        default: msg[i] = 8'($urandom_range(0, 255));
                    endcase
            end
            run(0, $urandom_range(1, 3), ev, term);
            if (term) do_reset();
            if ($urandom_range(0, 1) == 1) step();
        end

        // Exhaustion: walk key to the maximum, then one more invalid message.
        do_reset();
        fill(8'h61);
        msg[0] = 8'h00;
        for (int n = 0; n < KMAX; n++) run(0, 0, ev, term);
        check("pre_exh_key", bus.secret_key, 24'(KMAX));
        run(0, 0, ev, term);
        step();
        check("exh_flag", 24'(bus.key_exhausted), 24'h1);
        check("exh_key", bus.secret_key, 24'h00001F);
        check("exh_restart", 24'(bus.restart), 24'h0);
        do_reset();
        step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
